// File: rtl/prog_mem_arb.sv
// prog_mem_arb: owns the single program-memory port and shares it between instruction fetch
// and a debug/loader port. The core starts in HALT, Go moves it to RUN and HaltReq moves it back.
// In RUN, fetch has priority. A debug request that is starved for STARVE_MAX cycles gets one
// STEAL cycle in which the core is held.
// Optional feature: define PROG_MEM_WPROT_EN to reject debug writes below PROT_BASE.
module prog_mem_arb #(
  parameter int unsigned SIZE_LOG2  = 13,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned PROT_BASE  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SIZE_LOG2-1:0] FetchA,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 Go,
  input  logic                 HaltReq,
  output logic                 CoreHold,
  output logic [31:0]          InstrD,
  input  logic                 DbgReq,
  input  logic                 DbgWe,
  input  logic [SIZE_LOG2-1:0] DbgA,
  input  logic [31:0]          DbgWD,
  output logic                 DbgGnt,
  output logic                 DbgRValid,
  output logic [31:0]          DbgRD,
  output logic                 DbgErr,
  output logic                 MemEn,
  output logic                 MemWE,
  output logic [SIZE_LOG2-1:0] MemA,
  output logic [31:0]          MemWD,
  input  logic [31:0]          MemRD
);

  localparam int unsigned          CntW     = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0]      CntLast  = CntW'(STARVE_MAX - 1);
  localparam logic [SIZE_LOG2-1:0] ProtBase = SIZE_LOG2'(PROT_BASE);

  typedef enum logic [1:0] {StHalt, StRun, StSteal} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic            fetch_tag_q, fetch_tag_d;
  logic            rd_tag_q, rd_tag_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     dbg_rd_q, dbg_rd_d;
  logic            fetch_use, dbg_use, dbg_wait, starve_hit, wr_blocked;

`ifdef PROG_MEM_WPROT_EN
  // Writes into the protected low region are granted but never reach the memory.
  assign wr_blocked = DbgWe && (DbgA < ProtBase);
`else
  logic unused_prot_base;
  assign unused_prot_base = ^ProtBase;
  assign wr_blocked       = 1'b0;
`endif

  // Starvation: a request still waiting in RUN after STARVE_MAX cycles forces a steal.
  assign dbg_wait   = (state_q == StRun) && DbgReq && !dbg_use;
  assign starve_hit = dbg_wait && (starve_q == CntLast);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHalt;
      starve_q    <= '0;
      fetch_tag_q <= 1'b0;
      rd_tag_q    <= 1'b0;
      instr_q     <= '0;
      dbg_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      fetch_tag_q <= fetch_tag_d;
      rd_tag_q    <= rd_tag_d;
      instr_q     <= instr_d;
      dbg_rd_q    <= dbg_rd_d;
    end
  end

  // Next-state: HaltReq beats Go, and a steal lasts a single cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StHalt:  if (Go && !HaltReq) state_d = StRun;
      StRun: begin
        if (HaltReq)         state_d = StHalt;
        else if (starve_hit) state_d = StSteal;
      end
      StSteal: state_d = HaltReq ? StHalt : StRun;
      default: state_d = StHalt;
    endcase
  end

  // Port ownership and memory-side outputs.
  always_comb begin
    fetch_use = (state_q == StRun) && !StallD && !FlushD;
    // Keep the port quiet while reset is asserted even if a request is still being driven.
    dbg_use   = rst_n && DbgReq && !fetch_use;
    CoreHold  = (state_q != StRun);
    DbgGnt    = dbg_use;
    DbgErr    = dbg_use && wr_blocked;
    MemEn     = fetch_use || (dbg_use && !wr_blocked);
    MemWE     = dbg_use && DbgWe && !wr_blocked;
    MemA      = dbg_use ? DbgA : FetchA;
    MemWD     = dbg_use ? DbgWD : '0;
  end

  // Counter, result tags and the held copies of InstrD / DbgRD.
  always_comb begin
    starve_d    = (dbg_wait && !starve_hit) ? starve_q + 1'b1 : '0;
    fetch_tag_d = fetch_use;
    rd_tag_d    = dbg_use && !DbgWe;
    // MemRD is only forwarded in the cycle after the access that owned it.
    InstrD      = fetch_tag_q ? MemRD : instr_q;
    instr_d     = FlushD ? '0 : InstrD;
    DbgRValid   = rd_tag_q;
    DbgRD       = rd_tag_q ? MemRD : dbg_rd_q;
    dbg_rd_d    = DbgRD;
  end

endmodule

// File: tb/tb_prog_mem_arb.sv
// Bench for prog_mem_arb: directed scenarios followed by a random phase, with every cycle
// checked against a cycle-level behavioural model of the arbiter kept in this file.
module tb_prog_mem_arb;
  localparam int unsigned AW = 6;
  localparam int unsigned SM = 8;
  localparam int unsigned PB = 16;
  localparam int unsigned Words = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] FetchA, DbgA, MemA;
  logic          StallD, FlushD, Go, HaltReq, CoreHold;
  logic [31:0]   InstrD, DbgWD, DbgRD, MemWD, MemRD;
  logic          DbgReq, DbgWe, DbgGnt, DbgRValid, DbgErr, MemEn, MemWE;

  prog_mem_arb #(
    .SIZE_LOG2  (AW),
    .STARVE_MAX (SM),
    .PROT_BASE  (PB)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .FetchA    (FetchA),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .Go        (Go),
    .HaltReq   (HaltReq),
    .CoreHold  (CoreHold),
    .InstrD    (InstrD),
    .DbgReq    (DbgReq),
    .DbgWe     (DbgWe),
    .DbgA      (DbgA),
    .DbgWD     (DbgWD),
    .DbgGnt    (DbgGnt),
    .DbgRValid (DbgRValid),
    .DbgRD     (DbgRD),
    .DbgErr    (DbgErr),
    .MemEn     (MemEn),
    .MemWE     (MemWE),
    .MemA      (MemA),
    .MemWD     (MemWD),
    .MemRD     (MemRD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
  endfunction

  // Synchronous-read program memory, preloaded on the first edge.
  logic [31:0] ram [Words];
  logic        ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < int'(Words); i++) ram[i] <= pat(i);
      ram_loaded <= 1'b1;
    end else if (MemEn) begin
      if (MemWE) ram[MemA] <= MemWD;
      else       MemRD <= ram[MemA];
    end
  end

  // Behavioural reference.
  logic [31:0] ref_mem [Words];
  logic        m_halt, m_steal, m_rvalid;
  int          m_wait;
  logic [31:0] m_instr, m_rd;
  int          total = 0;
  int          bad = 0;
  logic        gnt_seen;
  int          gnt_cycle;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_halt   = 1'b1;
    m_steal  = 1'b0;
    m_wait   = 0;
    m_instr  = '0;
    m_rd     = '0;
    m_rvalid = 1'b0;
  endtask

  task automatic check_reset();
    check_eq("rst_hold", 32'(CoreHold), 32'd1);
    check_eq("rst_instr", InstrD, 32'd0);
    check_eq("rst_gnt", 32'(DbgGnt), 32'd0);
    check_eq("rst_rvalid", 32'(DbgRValid), 32'd0);
    check_eq("rst_rd", DbgRD, 32'd0);
    check_eq("rst_err", 32'(DbgErr), 32'd0);
    check_eq("rst_en", 32'(MemEn), 32'd0);
    check_eq("rst_we", 32'(MemWE), 32'd0);
  endtask

  task automatic dbg(input logic req, input logic we, input int a, input logic [31:0] wd);
    DbgReq = req;
    DbgWe  = we;
    DbgA   = AW'(a);
    DbgWD  = wd;
  endtask

  // Called just after a falling edge with inputs applied; checks this cycle and
  // advances the model across the next rising edge.
  task automatic step(output logic g);
    logic run, e_fetch, e_dbg, e_blk;
    #1;
    run     = !m_halt && !m_steal;
    e_fetch = run && !StallD && !FlushD;
    e_dbg   = DbgReq && !e_fetch;
`ifdef PROG_MEM_WPROT_EN
    e_blk   = e_dbg && DbgWe && (int'(DbgA) < int'(PB));
`else
    e_blk   = 1'b0;
`endif
    check_eq("hold", 32'(CoreHold), 32'(!run));
    check_eq("gnt", 32'(DbgGnt), 32'(e_dbg));
    check_eq("err", 32'(DbgErr), 32'(e_blk));
    check_eq("mem_en", 32'(MemEn), 32'((e_fetch || e_dbg) && !e_blk));
    check_eq("mem_we", 32'(MemWE), 32'(e_dbg && DbgWe && !e_blk));
    if (e_fetch || e_dbg) check_eq("mem_a", 32'(MemA), 32'(e_dbg ? DbgA : FetchA));
    if (e_dbg && DbgWe && !e_blk) check_eq("mem_wd", MemWD, DbgWD);
    check_eq("instr", InstrD, m_instr);
    check_eq("rvalid", 32'(DbgRValid), 32'(m_rvalid));
    check_eq("rdata", DbgRD, m_rd);
    g = DbgGnt;
    m_rvalid = e_dbg && !DbgWe;
    if (m_rvalid) m_rd = ref_mem[DbgA];
    if (e_dbg && DbgWe && !e_blk) ref_mem[DbgA] = DbgWD;
    if (FlushD)       m_instr = '0;
    else if (e_fetch) m_instr = ref_mem[FetchA];
    if (run && DbgReq && !e_dbg) m_wait++;
    else                         m_wait = 0;
    if (m_halt) begin
      m_halt = !(Go && !HaltReq);
    end else if (m_steal) begin
      m_steal = 1'b0;
      m_halt  = HaltReq;
    end else if (HaltReq) begin
      m_halt = 1'b1;
    end else if (m_wait == int'(SM)) begin
      m_steal = 1'b1;
      m_wait  = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < int'(Words); i++) ref_mem[i] = pat(i);
    model_reset();
    rst_n = 1'b0;
    FetchA = '0; StallD = 1'b0; FlushD = 1'b0; Go = 1'b0; HaltReq = 1'b0;
    dbg(1'b0, 1'b0, 0, 32'h0);
    repeat (2) @(negedge clk);
    check_reset();
    rst_n = 1'b1;

    // Loader write then read-back while halted.
    dbg(1'b1, 1'b1, 5, 32'hDEAD_BEEF);
    step(gnt_seen);
    dbg(1'b1, 1'b0, 5, 32'h0);
    step(gnt_seen);
    dbg(1'b0, 1'b0, 0, 32'h0);
    check_eq("halt_rvalid", 32'(DbgRValid), 32'd1);
    check_eq("halt_rd", DbgRD, 32'hDEAD_BEEF);
    step(gnt_seen);

`ifdef PROG_MEM_WPROT_EN
    dbg(1'b1, 1'b1, 3, 32'h1111_2222);
    step(gnt_seen);
    dbg(1'b1, 1'b0, 3, 32'h0);
    step(gnt_seen);
    check_eq("wp_low_rd", DbgRD, pat(3));
    dbg(1'b1, 1'b1, 16, 32'h3333_4444);
    step(gnt_seen);
    dbg(1'b1, 1'b0, 16, 32'h0);
    step(gnt_seen);
    check_eq("wp_high_rd", DbgRD, 32'h3333_4444);
    dbg(1'b0, 1'b0, 0, 32'h0);
`endif

    // Release and fetch words 0..3.
    Go = 1'b1;
    step(gnt_seen);
    Go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      FetchA = AW'(i);
      step(gnt_seen);
    end
    check_eq("fetch3", InstrD, pat(3));
    check_eq("run_hold", 32'(CoreHold), 32'd0);
    FetchA = AW'(4);
    step(gnt_seen);

    // Starved debug read under continuous fetch.
    dbg(1'b1, 1'b0, 5, 32'h0);
    gnt_cycle = 0;
    for (int k = 1; k <= 12; k++) begin
      FetchA = AW'(k);
      step(gnt_seen);
      if (gnt_seen) begin
        gnt_cycle = k;
        break;
      end
    end
    check_eq("starve_cycle", 32'(gnt_cycle), 32'(SM + 1));
    dbg(1'b0, 1'b0, 0, 32'h0);
    check_eq("steal_rd", DbgRD, 32'hDEAD_BEEF);
    repeat (3) step(gnt_seen);

    // Flush with stall over a pending fetch result; debug takes the free slot.
    FetchA = AW'(7);
    step(gnt_seen);
    StallD = 1'b1; FlushD = 1'b1;
    dbg(1'b1, 1'b0, 5, 32'h0);
    step(gnt_seen);
    check_eq("flush_gnt", 32'(gnt_seen), 32'd1);
    check_eq("flush_instr", InstrD, 32'd0);
    StallD = 1'b0; FlushD = 1'b0;
    dbg(1'b0, 1'b0, 0, 32'h0);
    step(gnt_seen);

    // HaltReq beats Go.
    HaltReq = 1'b1; Go = 1'b1;
    step(gnt_seen);
    HaltReq = 1'b0; Go = 1'b0;
    check_eq("halt_wins", 32'(CoreHold), 32'd1);
    Go = 1'b1;
    step(gnt_seen);
    Go = 1'b0;

    // Random traffic; a pending request stays stable until granted.
    gnt_seen = 1'b0;
    for (int c = 0; c < 800; c++) begin
      StallD  = (c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      FlushD  = ($urandom_range(0, 9) == 0);
      Go      = ($urandom_range(0, 19) == 0);
      HaltReq = ($urandom_range(0, 49) == 0);
      FetchA  = AW'($urandom);
      if (!(DbgReq && !gnt_seen)) begin
        dbg(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 23)), $urandom);
      end
      step(gnt_seen);
    end

    // Asynchronous reset right after a read grant drops the pending DbgRValid.
    StallD = 1'b1; FlushD = 1'b0; Go = 1'b0; HaltReq = 1'b0;
    dbg(1'b1, 1'b0, 9, 32'h0);
    step(gnt_seen);
    check_eq("pre_rst_gnt", 32'(gnt_seen), 32'd1);
    dbg(1'b0, 1'b0, 0, 32'h0);
    rst_n = 1'b0;
    #1;
    check_reset();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    StallD = 1'b0;
    repeat (3) step(gnt_seen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
